// File: rtl/dram_cmd_seq.sv
// Purpose: single-bank DRAM command sequencer (PRE/ACT/RD/WR) with open-row tracking.
// Latency: row hit -> command 1 cycle after accept; closed row +TRCD; row miss +TRP+TRCD.
// Backpressure: req_ready is high only in IDLE; one access in flight at a time.
// Ports: ACLK/ARESET (sync, active-high); req_* request in; rsp_* one-cycle
//        response pulses; idle mirrors the IDLE state; DRAM_* pins out, DRAM_Q/DRAM_valid in.
module dram_cmd_seq #(
    parameter int TRP        = 5,
    parameter int TRCD       = 5,
    parameter int TWR        = 5,
    parameter int RD_TIMEOUT = 63
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [20:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wen,
    output logic        rsp_rvalid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_wdone,
    output logic        rsp_err,
    output logic        idle,
    output logic        DRAM_CSn,
    output logic        DRAM_RASn,
    output logic        DRAM_CASn,
    output logic [3:0]  DRAM_WEn,
    output logic [10:0] DRAM_A,
    output logic [31:0] DRAM_D,
    input  logic [31:0] DRAM_Q,
    input  logic        DRAM_valid
);

    typedef enum logic [2:0] {IDLE, PRE, ACT, RD, RD_WAIT, WR, WR_REC, RSP} state_t;

    // Wait counts are loaded as N-1: the command cycle itself is the first of N.
    localparam logic [5:0] TRP_LD  = 6'(TRP - 1);
    localparam logic [5:0] TRCD_LD = 6'(TRCD - 1);
    localparam logic [5:0] TWR_LD  = 6'(TWR - 1);
    localparam logic [5:0] RDTO_LD = 6'(RD_TIMEOUT - 1);

    state_t      state;
    logic [5:0]  cnt;
    logic [10:0] open_row;
    logic        row_open;
    logic        wr_q;
    logic [20:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wen_q;

    logic        accept;
    logic        row_hit;
    logic        issue_act;
    logic        issue_col;
    logic [10:0] req_row;
    logic [10:0] act_row;
    logic        cur_write;
    logic [9:0]  cur_col;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wen;

    assign req_ready = (state == IDLE);
    assign idle      = (state == IDLE);
    assign accept    = (state == IDLE) && req_valid;
    assign req_row   = req_addr[20:10];
    assign row_hit   = row_open && (req_row == open_row);

    // ACT/column commands are issued either straight from IDLE (using the live
    // request) or at the end of a PRE/ACT wait (using the latched request).
    assign issue_act = (accept && !row_open) || (state == PRE && cnt == '0);
    assign issue_col = (accept && row_hit) || (state == ACT && cnt == '0);
    assign act_row   = (state == IDLE) ? req_row   : addr_q[20:10];
    assign cur_write = (state == IDLE) ? req_write : wr_q;
    assign cur_col   = (state == IDLE) ? req_addr[9:0] : addr_q[9:0];
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign cur_wen   = (state == IDLE) ? req_wen   : wen_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            cnt        <= '0;
            open_row   <= '0;
            row_open   <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 4'hF;
            rsp_rvalid <= 1'b0;
            rsp_wdone  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            DRAM_CSn   <= 1'b1;
            DRAM_RASn  <= 1'b1;
            DRAM_CASn  <= 1'b1;
            DRAM_WEn   <= 4'hF;
            DRAM_A     <= '0;
            DRAM_D     <= '0;
        end else begin
            // Default every cycle is a NOP; A and D keep their last value.
            DRAM_CSn   <= 1'b0;
            DRAM_RASn  <= 1'b1;
            DRAM_CASn  <= 1'b1;
            DRAM_WEn   <= 4'hF;
            rsp_rvalid <= 1'b0;
            rsp_wdone  <= 1'b0;
            rsp_err    <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_q    <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wen_q   <= req_wen;
                        if (row_open && !row_hit) begin
                            state     <= PRE;
                            cnt       <= TRP_LD;
                            DRAM_RASn <= 1'b0;
                            DRAM_WEn  <= 4'b0000;
                            DRAM_A    <= open_row;
                        end
                    end
                end
                PRE: if (cnt != '0) cnt <= cnt - 6'd1;
                ACT: if (cnt != '0) cnt <= cnt - 6'd1;
                RD: begin
                    state <= RD_WAIT;
                    cnt   <= RDTO_LD;
                end
                RD_WAIT: begin
                    if (DRAM_valid) begin
                        rsp_rdata  <= DRAM_Q;
                        rsp_rvalid <= 1'b1;
                        state      <= RSP;
                    end else if (cnt == '0) begin
                        // Data never came back: the row state is unknown, force a re-ACT.
                        rsp_err  <= 1'b1;
                        row_open <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                WR, WR_REC: begin
                    if (cnt == '0) begin
                        rsp_wdone <= 1'b1;
                        state     <= RSP;
                    end else begin
                        cnt   <= cnt - 6'd1;
                        state <= WR_REC;
                    end
                end
                RSP:     state <= IDLE;
                default: state <= IDLE;
            endcase

            if (issue_act) begin
                state     <= ACT;
                cnt       <= TRCD_LD;
                open_row  <= act_row;
                row_open  <= 1'b1;
                DRAM_RASn <= 1'b0;
                DRAM_A    <= act_row;
            end

            if (issue_col) begin
                DRAM_CASn <= 1'b0;
                DRAM_A    <= {1'b0, cur_col};
                if (cur_write) begin
                    state    <= WR;
                    cnt      <= TWR_LD;
                    DRAM_WEn <= cur_wen;
                    DRAM_D   <= cur_wdata;
                end else begin
                    state <= RD;
                end
            end
        end
    end

endmodule

// File: doc/dram_cmd_seq.md
DRAM_CMD_SEQ -- requirements
Module: dram_cmd_seq

Interface
REQ-001 SHALL have parameters: TRP, default 5, precharge-to-activate cycles; TRCD, default 5, activate-to-column cycles; TWR, default 5, write recovery cycles; RD_TIMEOUT, default 63, maximum cycles waiting for DRAM_valid.
REQ-002 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-003 SHALL have these ports (name  direction  width  meaning):
- ACLK  in  1  clock, rising edge
- ARESET  in  1  synchronous active-high reset
- req_valid  in  1  access request from the AXI slave FSM
- req_ready  out  1  request accepted this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  21  word address; row = [20:10], col = [9:0]
- req_wdata  in  32  write data
- req_wen  in  4  active-low byte write enable
- rsp_rvalid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  32  read data
- rsp_wdone  out  1  one-cycle pulse, write committed
- rsp_err  out  1  one-cycle pulse, read timeout
- idle  out  1  state is IDLE
- DRAM_CSn  out  1  chip select, active low
- DRAM_RASn  out  1  row strobe, active low
- DRAM_CASn  out  1  column strobe, active low
- DRAM_WEn  out  4  byte write enables, active low
- DRAM_A  out  11  row or column address
- DRAM_D  out  32  write data
- DRAM_Q  in  32  read data
- DRAM_valid  in  1  DRAM_Q valid

Function
REQ-004 SHALL implement these states: IDLE, PRE, ACT, RD, RD_WAIT, WR, WR_REC, RSP.
REQ-005 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready, and req_addr, req_wdata, req_wen and req_write are registered at that edge.
REQ-006 SHALL track the open row with an open_row register (11 bits) and a row_open flag.
REQ-007 On accept with a row hit (row_open && row == open_row), SHALL go directly to RD or WR.
REQ-008 On accept with a row miss and row_open set, SHALL go to PRE; with row_open clear, SHALL go to ACT.
REQ-009 Each command (PRE, ACT, RD, WR) SHALL drive its pin pattern for exactly one cycle, then NOP for the remaining wait cycles:
- PRE: RASn=0, CASn=1, WEn=4'b0000, A=open_row; then TRP-1 NOP cycles, then ACT.
- ACT: RASn=0, CASn=1, WEn=4'hF, A=new row; then TRCD-1 NOP cycles; open_row is updated and row_open set; then RD or WR.
- RD: RASn=1, CASn=0, WEn=4'hF, A={1'b0,col}; then RD_WAIT.
- WR: RASn=1, CASn=0, WEn=req_wen, A={1'b0,col}, D=wdata; then WR_REC for TWR-1 cycles.
REQ-010 NOP SHALL be RASn=1, CASn=1, WEn=4'hF; DRAM_A and DRAM_D SHALL hold their last value.
REQ-011 DRAM_CSn SHALL be 0 whenever not in reset.
REQ-012 In RD_WAIT, SHALL capture DRAM_Q into rsp_rdata on the first DRAM_valid, then go to RSP with rsp_rvalid=1 for one cycle.
REQ-013 In RD_WAIT, if RD_TIMEOUT cycles elapse without DRAM_valid, SHALL pulse rsp_err, clear row_open, and return to IDLE.
REQ-014 At the end of WR_REC, SHALL go to RSP with rsp_wdone=1 for one cycle.
REQ-015 From RSP, SHALL always go to IDLE; the minimum turnaround between two accepts is therefore one IDLE cycle.
REQ-016 The wait counter SHALL be 6 bits, loaded on command issue and decremented to 0; no wrap-around is permitted.
REQ-017 DRAM_valid outside RD_WAIT SHALL be ignored.
REQ-018 req_valid outside IDLE SHALL be ignored; the request is not accepted.
REQ-019 rsp_rvalid, rsp_wdone and rsp_err SHALL be mutually exclusive.

Reset
REQ-020 ARESET high at a clock edge SHALL force, from the next cycle:
- state = IDLE, row_open = 0, open_row = 0, counter = 0
- req_ready = 1, idle = 1
- rsp_rvalid = 0, rsp_wdone = 0, rsp_err = 0, rsp_rdata = 0
- DRAM_CSn = 1, DRAM_RASn = 1, DRAM_CASn = 1, DRAM_WEn = 4'hF, DRAM_A = 0, DRAM_D = 0
REQ-021 Reset asserted mid-operation SHALL abort the access with no response pulse.

Verification
REQ-022 Read to a closed bank, addr 0x00C05 (row 3, col 5) -> ACT with A=3, then exactly 5 cycles later RD with A=5; DRAM_valid with Q=0xDEADBEEF -> rsp_rvalid pulse with rsp_rdata=0xDEADBEEF.
REQ-023 Write to 0x00C06, wen=4'b1100, wdata=0x12345678, after REQ-022 (row hit) -> no PRE or ACT; WR with WEn=4'b1100 and D=0x12345678; rsp_wdone exactly TWR cycles after WR.
REQ-024 Read to 0x01005 (row 4) with row 3 open -> PRE (WEn=0000, A=3), ACT at +5 cycles (A=4), RD at +10 cycles.
REQ-025 Read with DRAM_valid never asserted -> rsp_err pulse after 63 cycles; the next access to the same row issues ACT.
REQ-026 ARESET asserted during RD_WAIT, then DRAM_valid -> no response; idle=1; the next access starts with ACT.
REQ-027 req_valid held high through an access -> exactly one accept per IDLE cycle; the command sequence is not restarted.
